// File: rtl/snake_query_arbiter_if.sv
// Bundle between the query arbiter, its three requesters, the collision checker and the body updater.
// The arbiter connects through the slave modport. The requester/checker side connects through master.
interface snake_query_arbiter_if #(
   parameter int COORD_W = 6
);
   logic [2:0]           req;
   logic [3*COORD_W-1:0] qx;
   logic [3*COORD_W-1:0] qy;
   logic [2:0]           gnt;
   logic [2:0]           rsp_valid;
   logic                 rsp_hit;
   logic [COORD_W-1:0]   inq_x;
   logic [COORD_W-1:0]   inq_y;
   logic                 inq_answer;
   logic                 body_busy;
   logic                 inq_busy;

   modport master (
      output req, qx, qy, inq_answer, body_busy,
      input  gnt, rsp_valid, rsp_hit, inq_x, inq_y, inq_busy
   );

   modport slave (
      input  req, qx, qy, inq_answer, body_busy,
      output gnt, rsp_valid, rsp_hit, inq_x, inq_y, inq_busy
   );
endinterface

// File: rtl/snake_query_arbiter.sv
// Shares the single collision checker between move, food and render requesters.
// Move has fixed priority; food and render alternate. Body updates are held off while a query is in flight.
//
// state | meaning
// IDLE  | no query in flight; may grant one requester and load checker coordinates
// EVAL  | checker settling on inq_x/inq_y; answer is captured and returned to the owner
module snake_query_arbiter #(
   parameter int COORD_W = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   snake_query_arbiter_if.slave  bus
);

   typedef enum logic {IDLE, EVAL} state_t;

   state_t               state_q, state_d;
   logic [2:0]           gnt_q, gnt_d;
   logic [2:0]           rsp_valid_q, rsp_valid_d;
   logic                 rsp_hit_q, rsp_hit_d;
   logic [COORD_W-1:0]   inq_x_q, inq_x_d;
   logic [COORD_W-1:0]   inq_y_q, inq_y_d;
   logic [1:0]           owner_q, owner_d;
   logic                 rr_render_q, rr_render_d;
   logic [1:0]           win;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= 3'b000;
         rsp_valid_q <= 3'b000;
         rsp_hit_q   <= 1'b0;
         inq_x_q     <= '0;
         inq_y_q     <= '0;
         owner_q     <= 2'd0;
         rr_render_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         inq_x_q     <= inq_x_d;
         inq_y_q     <= inq_y_d;
         owner_q     <= owner_d;
         rr_render_q <= rr_render_d;
      end
   end

   // Move always wins. Between food and render, the rr pointer breaks the tie.
   always_comb begin
      win = 2'd0;
      if (bus.req[0])                      win = 2'd0;
      else if (bus.req[1] && bus.req[2])   win = rr_render_q ? 2'd2 : 2'd1;
      else if (bus.req[1])                 win = 2'd1;
      else if (bus.req[2])                 win = 2'd2;
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = 3'b000;
      rsp_valid_d = 3'b000;
      rsp_hit_d   = rsp_hit_q;
      inq_x_d     = inq_x_q;
      inq_y_d     = inq_y_q;
      owner_d     = owner_q;
      rr_render_d = rr_render_q;
      case (state_q)
         IDLE: begin
            if (!bus.body_busy && (bus.req != 3'b000)) begin
               case (win)
                  2'd1: begin
                     inq_x_d = bus.qx[COORD_W +: COORD_W];
                     inq_y_d = bus.qy[COORD_W +: COORD_W];
                     gnt_d   = 3'b010;
                  end
                  2'd2: begin
                     inq_x_d = bus.qx[2*COORD_W +: COORD_W];
                     inq_y_d = bus.qy[2*COORD_W +: COORD_W];
                     gnt_d   = 3'b100;
                  end
                  default: begin
                     inq_x_d = bus.qx[0 +: COORD_W];
                     inq_y_d = bus.qy[0 +: COORD_W];
                     gnt_d   = 3'b001;
                  end
               endcase
               if (win != 2'd0) rr_render_d = (win == 2'd1);
               owner_d = win;
               state_d = EVAL;
            end
         end
         EVAL: begin
            rsp_hit_d = bus.inq_answer;
            case (owner_q)
               2'd1:    rsp_valid_d = 3'b010;
               2'd2:    rsp_valid_d = 3'b100;
               default: rsp_valid_d = 3'b001;
            endcase
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.gnt       = gnt_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_hit   = rsp_hit_q;
   assign bus.inq_x     = inq_x_q;
   assign bus.inq_y     = inq_y_q;
   assign bus.inq_busy  = (state_q == EVAL);

endmodule

// File: tb/tb_snake_query_arbiter.sv
// Directed and random checks of snake_query_arbiter against a request/response reference model.
// The model also includes a simple wall-plus-body collision checker.
module tb_snake_query_arbiter;

   localparam int CW = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;

   snake_query_arbiter_if #(.COORD_W(CW)) bus ();

   snake_query_arbiter #(.COORD_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Checker model: play field walls plus an occupancy map of body cells.
   logic body_map [64][64];

   function automatic logic is_wall(logic [CW-1:0] x, logic [CW-1:0] y);
      return (x == 0) || (y == 0) || (x >= 39) || (y >= 29);
   endfunction

   always_comb bus.inq_answer = is_wall(bus.inq_x, bus.inq_y) || body_map[bus.inq_x][bus.inq_y];

   // Reference model: one outstanding query, answered on the following edge.
   int              m_pref;
   bit              m_inflight;
   int              m_owner;
   logic [2:0]      m_gnt, m_rv;
   logic            m_hit;
   logic [CW-1:0]   m_x, m_y;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pref = 1; m_inflight = 0; m_owner = 0;
      m_gnt = 0; m_rv = 0; m_hit = 0; m_x = 0; m_y = 0;
   endtask

   task automatic step();
      int w;
      logic [2:0] g, v;
      g = 3'b000;
      v = 3'b000;
      w = 0;
      if (m_inflight) begin
         v = 3'(1 << m_owner);
         m_hit = is_wall(m_x, m_y) || body_map[m_x][m_y];
         m_inflight = 0;
      end else if (!bus.body_busy && bus.req != 3'b000) begin
         if (bus.req[0])                    w = 0;
         else if (bus.req[1] && bus.req[2]) w = m_pref;
         else if (bus.req[1])               w = 1;
         else                               w = 2;
         if (w != 0) m_pref = 3 - w;
         m_x = bus.qx[w*CW +: CW];
         m_y = bus.qy[w*CW +: CW];
         m_owner = w;
         m_inflight = 1;
         g = 3'(1 << w);
      end
      m_gnt = g;
      m_rv = v;
      @(posedge clk);
      #1;
      chk("gnt",       bus.gnt,       m_gnt);
      chk("rsp_valid", bus.rsp_valid, m_rv);
      chk("rsp_hit",   bus.rsp_hit,   m_hit);
      chk("inq_x",     bus.inq_x,     m_x);
      chk("inq_y",     bus.inq_y,     m_y);
      chk("inq_busy",  bus.inq_busy,  m_inflight);
   endtask

   task automatic set_q(int i, int x, int y);
      bus.qx[i*CW +: CW] = CW'(x);
      bus.qy[i*CW +: CW] = CW'(y);
   endtask

   initial begin
      logic [2:0] pend;
      int x, y;
      for (int i = 0; i < 64; i++)
         for (int j = 0; j < 64; j++) body_map[i][j] = 1'b0;
      bus.req = 3'b000;
      bus.qx = '0;
      bus.qy = '0;
      bus.body_busy = 1'b0;
      model_reset();

      // Reset state
      #12;
      chk("rst_gnt", bus.gnt, 3'b000);
      chk("rst_rv", bus.rsp_valid, 3'b000);
      chk("rst_hit", bus.rsp_hit, 1'b0);
      chk("rst_x", bus.inq_x, 0);
      chk("rst_y", bus.inq_y, 0);
      chk("rst_busy", bus.inq_busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single move query hitting the body
      body_map[10][10] = 1'b1;
      set_q(0, 10, 10);
      bus.req = 3'b001;
      step();
      chk("move_gnt", bus.gnt, 3'b001);
      chk("move_x", bus.inq_x, 10);
      chk("move_y", bus.inq_y, 10);
      bus.req = 3'b000;
      step();
      chk("move_rv", bus.rsp_valid, 3'b001);
      chk("move_hit", bus.rsp_hit, 1'b1);
      body_map[10][10] = 1'b0;

      // Move held with everyone requesting keeps winning
      set_q(1, 7, 8);
      set_q(2, 9, 11);
      bus.req = 3'b111;
      step();
      chk("prio_g0", bus.gnt, 3'b001);
      step();
      step();
      chk("prio_g1", bus.gnt, 3'b001);
      bus.req = 3'b110;
      step();
      step();
      chk("rr_g0", bus.gnt, 3'b010);
      step();
      step();
      chk("rr_g1", bus.gnt, 3'b100);
      step();
      step();
      chk("rr_g2", bus.gnt, 3'b010);
      step();
      step();
      chk("rr_g3", bus.gnt, 3'b100);
      bus.req = 3'b000;
      step();

      // Wall query, then a free cell
      set_q(1, 0, 5);
      bus.req = 3'b010;
      step();
      chk("wall_gnt", bus.gnt, 3'b010);
      bus.req = 3'b000;
      step();
      chk("wall_rv", bus.rsp_valid, 3'b010);
      chk("wall_hit", bus.rsp_hit, 1'b1);
      set_q(1, 20, 20);
      bus.req = 3'b010;
      step();
      bus.req = 3'b000;
      step();
      chk("free_rv", bus.rsp_valid, 3'b010);
      chk("free_hit", bus.rsp_hit, 1'b0);

      // Body interlock blocks grants
      bus.body_busy = 1'b1;
      bus.req = 3'b010;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("lock_gnt", bus.gnt, 3'b000);
         chk("lock_busy", bus.inq_busy, 1'b0);
      end
      bus.body_busy = 1'b0;
      step();
      chk("unlock_gnt", bus.gnt, 3'b010);
      bus.req = 3'b000;
      step();

      // body_busy rising during EVAL does not abort the query
      set_q(2, 3, 4);
      bus.req = 3'b100;
      step();
      chk("eval_gnt", bus.gnt, 3'b100);
      bus.body_busy = 1'b1;
      bus.req = 3'b001;
      step();
      chk("eval_rv", bus.rsp_valid, 3'b100);
      step();
      chk("eval_hold0", bus.gnt, 3'b000);
      step();
      chk("eval_hold1", bus.gnt, 3'b000);
      bus.body_busy = 1'b0;
      step();
      chk("eval_release", bus.gnt, 3'b001);
      bus.req = 3'b000;
      step();

      // Reset in the middle of EVAL drops the query
      bus.req = 3'b010;
      step();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_gnt", bus.gnt, 3'b000);
      chk("mid_rv", bus.rsp_valid, 3'b000);
      chk("mid_hit", bus.rsp_hit, 1'b0);
      chk("mid_x", bus.inq_x, 0);
      chk("mid_busy", bus.inq_busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.req = 3'b110;
      step();
      chk("post_rst_rv", bus.rsp_valid, 3'b000);
      chk("post_rst_gnt", bus.gnt, 3'b010);
      bus.req = 3'b000;
      step();

      // Random requesters holding until granted, random body updates under interlock
      pend = 3'b000;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (m_gnt[i]) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               set_q(i, $urandom_range(0, 45), $urandom_range(0, 35));
            end else if (pend[i] && $urandom_range(0, 19) == 0) begin
               pend[i] = 1'b0;
            end
         end
         bus.req = pend;
         bus.body_busy = ($urandom_range(0, 3) == 0);
         if (bus.body_busy && !m_inflight) begin
            x = $urandom_range(1, 38);
            y = $urandom_range(1, 28);
            body_map[x][y] = ~body_map[x][y];
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
